// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/
// writeback, drives every datapath enable and mux select, and handshakes
// with a variable-latency memory over mem_req/mem_ready.
// Optional build macro MC_TRAP_EN: adds the illegal-instruction trap and
// the bus-timeout trap (wait counter + TRAP state). Without it, illegal
// instructions behave as a NOP and memory waits are unbounded.
module multicycle_controller #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] aluctrl,
  output logic [3:0] state,
  output logic       exc,
  output logic [1:0] exc_cause
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic       w_func_ok;
  logic [2:0] w_func_alu;
  logic       w_illegal;

`ifdef MC_TRAP_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  // Count value seen during the MAX_WAIT-th consecutive low cycle.
  localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);

  logic [WW-1:0] r_wait;
  logic [1:0]    r_cause;
  logic          w_timeout;
  logic          w_req_state;

  assign w_req_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  assign w_timeout   = !mem_ready && (r_wait == LAST_WAIT);
`endif

  // Decode the R-type function field into an ALU operation and legality.
  always_comb begin
    w_func_ok  = 1'b1;
    w_func_alu = 3'b010;
    case (func)
      6'b100000: w_func_alu = 3'b010;
      6'b100010: w_func_alu = 3'b110;
      6'b100100: w_func_alu = 3'b000;
      6'b100101: w_func_alu = 3'b001;
      6'b101010: w_func_alu = 3'b111;
      default:   w_func_ok  = 1'b0;
    endcase
  end

  // Next-state logic; memory states advance only on the handshake.
  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          if (r_state == S_FETCH)      w_next = S_DECODE;
          else if (r_state == S_MEMRD) w_next = S_MEMWB;
          else                         w_next = S_FETCH;
        end
`ifdef MC_TRAP_EN
        else if (w_timeout) begin
          w_next = S_TRAP;
        end
`endif
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE: begin
            if (w_func_ok) w_next = S_EXEC;
            else           w_illegal = 1'b1;
          end
          OP_BEQ:  w_next = S_BRANCH;
          OP_ADDI: w_next = S_ADDIEX;
          OP_J:    w_next = S_JUMP;
          default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
`ifdef MC_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_FETCH;
`endif
        end
      end
      S_MEMADR: w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMWB:  w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
`ifdef MC_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

`ifdef MC_TRAP_EN
  // Wait counter: consecutive mem_ready-low cycles within one access.
  always_ff @(posedge clk) begin
    if (reset || mem_ready || (w_next != r_state)) r_wait <= '0;
    else if (w_req_state)                          r_wait <= r_wait + 1'b1;
  end

  // Latch the trap cause on entry to TRAP.
  always_ff @(posedge clk) begin
    if (reset)
      r_cause <= 2'b00;
    else if ((r_state != S_TRAP) && (w_next == S_TRAP))
      r_cause <= (r_state == S_DECODE) ? 2'b01 : 2'b10;
  end
`endif

  // Moore outputs from the state, with handshake/zero qualified enables;
  // everything is forced low while reset is asserted.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluctrl    = 3'b000;
    state      = 4'd0;
    exc        = 1'b0;
    exc_cause  = 2'b00;
    if (!reset) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          aluctrl   = 3'b010;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          aluctrl   = 3'b010;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluctrl   = 3'b010;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          aluctrl   = w_func_alu;
        end
        S_ALUWB: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          aluctrl   = 3'b110;
          pc_src    = 2'b01;
          pc_we     = zero;
        end
        S_ADDIWB: reg_we = 1'b1;
        S_JUMP: begin
          pc_we  = 1'b1;
          pc_src = 2'b10;
        end
`ifdef MC_TRAP_EN
        S_TRAP: begin
          exc       = 1'b1;
          exc_cause = r_cause;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
